// File: rtl/program_loader_pkg.sv
// ----------------------------------------------------------------------------
// program_loader_pkg
// Shared constants for the program loader: byte/lane geometry and the FSM
// state encoding.
// Optional feature macro: LOADER_CHECKSUM_EN. When it is defined, a checksum
// byte follows the data and the FSM passes through ST_CHK before ST_DONE.
// ----------------------------------------------------------------------------
package program_loader_pkg;

  localparam int LANES  = 4;
  localparam int BYTE_W = 8;
  localparam int WORD_W = LANES * BYTE_W;
  localparam int LANE_W = $clog2(LANES);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LEN_LO = 3'd1;
  localparam logic [2:0] ST_LEN_HI = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_CHK    = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;
  localparam logic [2:0] ST_ERR    = 3'd6;

  // State entered once the last word is written (or for an empty program).
  function automatic logic [2:0] end_of_data_state();
`ifdef LOADER_CHECKSUM_EN
    return ST_CHK;
`else
    return ST_DONE;
`endif
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// ----------------------------------------------------------------------------
// program_loader_if
// Bundles the incoming byte stream (valid/ready) and the program-memory
// write port of the loader.
//   in_valid/in_data  : byte stream towards the loader
//   in_ready          : loader accepts a byte this cycle
//   mem_we/mem_addr/mem_wdata : one-cycle word write into program memory
// Modports: master = stream source / memory side, slave = the loader.
// ----------------------------------------------------------------------------
interface program_loader_if #(
  parameter int ADDR_W = 8
);
  import program_loader_pkg::*;

  logic              in_valid;
  logic [BYTE_W-1:0] in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/program_loader_word_assembler.sv
// ----------------------------------------------------------------------------
// word_assembler
// Packs accepted bytes little-endian into 32-bit words (first byte ->
// bits [7:0]). A lane counter wraps 3 -> 0; the cycle after the fourth byte
// of a word, o_word_valid pulses for one cycle with the complete word.
// Ports:
//   i_clk, i_rst_n   : clock, synchronous active-low reset
//   i_clear          : restart at lane 0 (new load)
//   i_byte_valid     : a byte is transferred this cycle
//   i_byte           : the byte
//   o_word_valid     : one-cycle pulse, o_word holds a complete word
//   o_word           : assembled word
// ----------------------------------------------------------------------------
module word_assembler
  import program_loader_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_byte_valid,
  input  logic [BYTE_W-1:0] i_byte,
  output logic              o_word_valid,
  output logic [WORD_W-1:0] o_word
);

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  logic [LANE_W-1:0] r_lane;
  logic [WORD_W-1:0] r_word;
  logic              r_word_valid;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the values from before the clock edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_lane       <= '0;
      // NOTE: the data register is reset as well because mem_wdata must read
      // 0 after reset; pure datapath storage would normally be left unreset.
      r_word       <= '0;
      r_word_valid <= 1'b0;
    end else begin
      r_word_valid <= 1'b0;
      if (i_clear) begin
        r_lane <= '0;
      end else if (i_byte_valid) begin
        r_word[r_lane*BYTE_W +: BYTE_W] <= i_byte;
        r_lane       <= r_lane + LANE_W'(1);
        r_word_valid <= (r_lane == LAST_LANE);
      end
    end
  end

  // The lane-0 byte of the next word may overwrite bits [7:0] at the edge
  // that ends the valid pulse, so the word is stable while it is flagged.
  assign o_word_valid = r_word_valid;
  assign o_word       = r_word;

endmodule

// File: rtl/program_loader.sv
// ----------------------------------------------------------------------------
// program_loader
// Fills the instruction program memory from a byte stream:
//   2-byte little-endian word count, then little-endian 32-bit words
//   [, then one checksum byte when LOADER_CHECKSUM_EN is defined].
// Words are written sequentially from address 0. The pipelined core is held
// in reset (o_core_rst_n = 0) until a load completes successfully.
// Optional feature macro: LOADER_CHECKSUM_EN (checksum byte = mod-256 sum of
// all data bytes; mismatch -> error).
// Ports:
//   i_clk, i_rst_n   : clock, synchronous active-low reset
//   i_load_start     : pulse, begins a new load from IDLE/DONE/ERR
//   bus (slave)      : byte stream in, program-memory write port out
//   o_core_rst_n     : active-low core reset, released only in DONE
//   o_load_done      : load finished successfully
//   o_load_err       : load aborted (length overflow / checksum mismatch)
//   o_words_loaded   : words written by the current/last load
// ----------------------------------------------------------------------------
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load_start,
  program_loader_if.slave   bus,
  output logic              o_core_rst_n,
  output logic              o_load_done,
  output logic              o_load_err,
  output logic [ADDR_W:0]   o_words_loaded
);

  localparam logic [16:0] MAX_WORDS = 17'(2**ADDR_W);

  logic [2:0]        r_state;
  logic [2:0]        w_next_state;
  logic [7:0]        r_len_lo;
  logic [ADDR_W:0]   r_count;
  logic [ADDR_W:0]   r_word_idx;
  logic [ADDR_W+2:0] r_byte_cnt;
  logic              r_load_done;
  logic              r_load_err;
  logic              r_core_rst_n;

  logic              w_in_ready;
  logic              w_xfer;
  logic              w_start;
  logic [15:0]       w_len;
  logic              w_len_too_big;
  logic [ADDR_W:0]   w_idx_next;
  logic              w_word_valid;
  logic [WORD_W-1:0] w_word;

  assign w_xfer        = bus.in_valid & w_in_ready;
  assign w_start       = i_load_start &&
                         (r_state inside {ST_IDLE, ST_DONE, ST_ERR});
  assign w_len         = {bus.in_data, r_len_lo};
  assign w_len_too_big = {1'b0, w_len} > MAX_WORDS;
  assign w_idx_next    = r_word_idx + (ADDR_W+1)'(1);

  word_assembler u_word_assembler (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_clear      (w_start),
    .i_byte_valid (w_xfer && (r_state == ST_DATA)),
    .i_byte       (bus.in_data),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] r_sum;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sum <= '0;
    end else if (w_start) begin
      r_sum <= '0;
    end else if (w_xfer && (r_state == ST_DATA)) begin
      r_sum <= r_sum + bus.in_data;
    end
  end
`endif

  // In DATA, ready drops once every byte of the announced length has been
  // taken, so nothing is swallowed while the last word is being written.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    w_in_ready = 1'b0;
    case (r_state)
      ST_LEN_LO, ST_LEN_HI: w_in_ready = 1'b1;
      ST_DATA:   w_in_ready = (r_byte_cnt != {r_count, {LANE_W{1'b0}}});
`ifdef LOADER_CHECKSUM_EN
      ST_CHK:    w_in_ready = 1'b1;
`endif
      default:   w_in_ready = 1'b0;
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (i_load_start) w_next_state = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (w_xfer) w_next_state = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        if (w_xfer) begin
          if (w_len == 16'd0)     w_next_state = end_of_data_state();
          else if (w_len_too_big) w_next_state = ST_ERR;
          else                    w_next_state = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_word_valid && (w_idx_next == r_count))
          w_next_state = end_of_data_state();
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (w_xfer) w_next_state = (bus.in_data == r_sum) ? ST_DONE : ST_ERR;
      end
`endif
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_len_lo     <= '0;
      r_count      <= '0;
      r_word_idx   <= '0;
      r_byte_cnt   <= '0;
      r_load_done  <= 1'b0;
      r_load_err   <= 1'b0;
      r_core_rst_n <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      // Status follows the state one cycle later; a restart clears it at once.
      r_load_done  <= (r_state == ST_DONE) && !i_load_start;
      r_core_rst_n <= (r_state == ST_DONE) && !i_load_start;
      r_load_err   <= (r_state == ST_ERR)  && !i_load_start;
      if (w_start) begin
        r_count    <= '0;
        r_word_idx <= '0;
        r_byte_cnt <= '0;
      end else begin
        if (w_xfer && (r_state == ST_LEN_LO)) r_len_lo <= bus.in_data;
        // An oversized length is truncated here, but the FSM goes to ERR.
        if (w_xfer && (r_state == ST_LEN_HI)) r_count <= w_len[ADDR_W:0];
        if (w_xfer && (r_state == ST_DATA))
          r_byte_cnt <= r_byte_cnt + (ADDR_W+3)'(1);
        if (w_word_valid) r_word_idx <= w_idx_next;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.mem_we    = w_word_valid;
  assign bus.mem_addr  = r_word_idx[ADDR_W-1:0];
  assign bus.mem_wdata = w_word;

  assign o_core_rst_n   = r_core_rst_n;
  assign o_load_done    = r_load_done;
  assign o_load_err     = r_load_err;
  assign o_words_loaded = r_word_idx;

endmodule

// File: tb/tb_program_loader.sv
// ----------------------------------------------------------------------------
// tb_program_loader
// Drives program_loader with directed and $urandom byte streams. A reference
// model keeps the expected program-memory image as a plain array and the
// program as a queue of words; the expected outcome of each load follows
// from the stream format rules. The memory side of the DUT is mirrored from
// its write strobes and compared against the model image.
// Build with +define+LOADER_CHECKSUM_EN to exercise the checksum option.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_program_loader;
  import program_loader_pkg::*;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            load_start = 1'b0;
  logic            core_rst_n;
  logic            load_done;
  logic            load_err;
  logic [ADDR_W:0] words_loaded;

  program_loader_if #(.ADDR_W(ADDR_W)) bus ();

  program_loader #(.ADDR_W(ADDR_W)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_load_start   (load_start),
    .bus            (bus),
    .o_core_rst_n   (core_rst_n),
    .o_load_done    (load_done),
    .o_load_err     (load_err),
    .o_words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [31:0] model_mem [DEPTH];
  logic [31:0] words_q [$];

  // Mirror of the DUT-written memory and the write log of the current load
  logic [31:0]       dut_mem [DEPTH];
  logic [ADDR_W-1:0] wr_addr_q [$];
  logic [31:0]       wr_data_q [$];
  int                we_in_err   = 0;
  int                ready_drops = 0;
  bit                in_data_phase = 1'b0;

  always @(negedge clk) begin
    if (bus.mem_we) begin
      dut_mem[bus.mem_addr] = bus.mem_wdata;
      wr_addr_q.push_back(bus.mem_addr);
      wr_data_q.push_back(bus.mem_wdata);
      if (load_err) we_in_err++;
    end
  end

  function automatic logic [7:0] model_checksum();
    logic [7:0] s = 8'h00;
    foreach (words_q[i]) begin
      logic [31:0] w = words_q[i];
      s = s + w[7:0] + w[15:8] + w[23:16] + w[31:24];
    end
    return s;
  endfunction

  // All tasks start and end at a falling edge.
  task automatic pulse_start();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int gap = gaps ? int'($urandom_range(0, 3)) : 0;
    bit got_ready = 1'b0;
    repeat (gap) begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
      @(negedge clk);
      if (in_data_phase && !bus.in_ready) ready_drops++;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int k = 0; k < 40; k++) begin
      if (bus.in_ready) begin
        got_ready = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got_ready) begin
      check("ready_timeout", 0, 1);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
  endtask

  task automatic wait_end();
    for (int k = 0; k < 16 && !(load_done || load_err); k++) @(negedge clk);
    check("end_timeout", load_done || load_err, 1);
  endtask

  // Full load of words_q; chk_delta corrupts the checksum byte when nonzero.
  task automatic run_load(input bit gaps, input bit poke_start, input logic [7:0] chk_delta);
    int   n = words_q.size();
    bit   exp_err;
    int   bad;
    logic [31:0] wd;
    wr_addr_q.delete();
    wr_data_q.delete();
    ready_drops = 0;
    pulse_start();
    check("start_core_rst_n", core_rst_n, 0);
    check("start_done", load_done, 0);
    check("start_err", load_err, 0);
    send_byte(n[7:0], 1'b0);
    send_byte(n[15:8], 1'b0);
    in_data_phase = 1'b1;
    for (int w = 0; w < n; w++) begin
      wd = words_q[w];
      for (int k = 0; k < 4; k++) begin
        send_byte(wd[8*k +: 8], gaps);
        if (poke_start && w == 0 && k == 0) pulse_start();
      end
    end
    in_data_phase = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    send_byte(model_checksum() + chk_delta, 1'b0);
    exp_err = (chk_delta != 8'h00);
`else
    exp_err = (chk_delta != 8'h00) && 1'b0;
    if (n > 0) begin
      check("lat_mem_we", bus.mem_we, 1);
      check("lat_mem_addr", bus.mem_addr, n - 1);
      @(negedge clk);
      check("lat_done_n1", load_done, 0);
      @(negedge clk);
      check("lat_done_n2", load_done, 1);
      check("lat_core_rst_n2", core_rst_n, 1);
    end
`endif
    wait_end();
    @(negedge clk);
    check("load_done", load_done, !exp_err);
    check("load_err", load_err, exp_err);
    check("core_rst_n", core_rst_n, !exp_err);
    check("words_loaded", words_loaded, n);
    check("in_ready_idle", bus.in_ready, 0);
    check("ready_drops", ready_drops, 0);
    check("write_count", wr_addr_q.size(), n);
    bad = 0;
    foreach (wr_addr_q[i]) begin
      if (i >= n || wr_addr_q[i] != ADDR_W'(i) || wr_data_q[i] != words_q[i]) bad++;
    end
    check("write_order", bad, 0);
    for (int i = 0; i < n; i++) model_mem[i] = words_q[i];
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (dut_mem[i] !== model_mem[i]) bad++;
    check("mem_image", bad, 0);
  endtask

  task automatic run_bad_len(input logic [15:0] len);
    wr_addr_q.delete();
    wr_data_q.delete();
    pulse_start();
    send_byte(len[7:0], 1'b0);
    send_byte(len[15:8], 1'b0);
    wait_end();
    @(negedge clk);
    check("badlen_err", load_err, 1);
    check("badlen_done", load_done, 0);
    check("badlen_core_rst_n", core_rst_n, 0);
    check("badlen_writes", wr_addr_q.size(), 0);
    check("badlen_words", words_loaded, 0);
    check("badlen_ready", bus.in_ready, 0);
  endtask

  task automatic random_words(input int n);
    words_q.delete();
    for (int i = 0; i < n; i++) words_q.push_back($urandom);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i] = 32'h0;
      dut_mem[i]   = 32'h0;
    end

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_core_rst_n", core_rst_n, 0);
    check("rst_load_done", load_done, 0);
    check("rst_load_err", load_err, 0);
    check("rst_words_loaded", words_loaded, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed two-word program
    words_q = '{32'h00100013, 32'h00200093};
    run_load(1'b0, 1'b0, 8'h00);

    // Length one past capacity
    run_bad_len(16'h0101);

    // Empty program
    words_q.delete();
    run_load(1'b0, 1'b0, 8'h00);

    // Random valid gaps, three words
    random_words(3);
    run_load(1'b1, 1'b0, 8'h00);

    // Reset in the middle of the first word
    random_words(3);
    wr_addr_q.delete();
    pulse_start();
    send_byte(8'd3, 1'b0);
    send_byte(8'd0, 1'b0);
    send_byte(8'($urandom), 1'b0);
    send_byte(8'($urandom), 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", bus.in_ready, 0);
    check("midrst_mem_we", bus.mem_we, 0);
    check("midrst_mem_wdata", bus.mem_wdata, 0);
    check("midrst_core_rst_n", core_rst_n, 0);
    check("midrst_done", load_done, 0);
    check("midrst_err", load_err, 0);
    check("midrst_words", words_loaded, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_no_write", wr_addr_q.size(), 0);
    random_words(1);
    run_load(1'b1, 1'b0, 8'h00);

    // load_start while in DATA is ignored
    random_words(4);
    run_load(1'b1, 1'b1, 8'h00);

    // Full capacity
    random_words(DEPTH);
    run_load(1'b0, 1'b0, 8'h00);

    // Random loads overwriting from address 0
    for (int r = 0; r < 4; r++) begin
      random_words(int'($urandom_range(1, 10)));
      run_load(1'($urandom), 1'b0, 8'h00);
    end

`ifdef LOADER_CHECKSUM_EN
    words_q = '{32'h00100013, 32'h00200093};
    run_load(1'b0, 1'b0, 8'h00);
    run_load(1'b0, 1'b0, 8'h01);
    random_words(5);
    run_load(1'b1, 1'b0, 8'($urandom_range(1, 255)));
    words_q.delete();
    run_load(1'b0, 1'b0, 8'h00);
`endif

    check("mem_we_during_err", we_in_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
